// File: rtl/level_pkg.sv
// level_pkg
// Shared definitions for the tank level-sensor conditioner:
//   - debounce channel state encoding
//   - level code forced onto I/S while a sensor fault is latched
//   - default parameter values
package level_pkg;

  // Debounce channel state: STABLE while the synchronised sample matches the
  // held value, PEND while a differing sample is being counted.
  typedef enum logic {
    STABLE = 1'b0,
    PEND   = 1'b1
  } db_state_t;

  // Forced level code during a fault: report the tank as full so the pump
  // controller shuts off both pumps.
  localparam logic FAULT_I = 1'b1;
  localparam logic FAULT_S = 1'b1;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_FAULT_CYCLES    = 8;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
// One raw float-switch input: 2-flop synchroniser followed by a debouncer.
// The held value only flips after DEBOUNCE_CYCLES consecutive synchronised
// samples that differ from it.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  synchronous active-high reset
//   raw    in  asynchronous raw switch input
//   level  out debounced (held) level
module debounce_channel
  import level_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  db_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          held_reg, held_next;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    held_next  = held_reg;
    if (sync2_reg != held_reg) begin
      // The terminal count is only reachable from PEND because the legal
      // DEBOUNCE_CYCLES is at least 2, so LAST is never 0.
      if (state_reg == PEND && cnt_reg == LAST) begin
        held_next  = sync2_reg;
        cnt_next   = '0;
        state_next = STABLE;
      end else begin
        cnt_next   = cnt_reg + CW'(1);
        state_next = PEND;
      end
    end else begin
      cnt_next   = '0;
      state_next = STABLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      state_reg <= STABLE;
      cnt_reg   <= '0;
      held_reg  <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      held_reg  <= held_next;
    end
  end

  assign level = held_reg;

endmodule

// File: rtl/level_sensor_conditioner.sv
// level_sensor_conditioner
// Conditions the raw low (i_raw) and high (s_raw) float switches into the
// clean I/S inputs of the two-pump controller. Each input is synchronised
// and debounced independently; a debounced pair of S=1, I=0 (water above the
// high switch but below the low one) held for FAULT_CYCLES cycles latches a
// sticky fault, during which I=S=1 is forced so both pumps stop.
// Ports:
//   clk        in  system clock, rising edge
//   reset      in  synchronous active-high reset
//   i_raw      in  raw low-level switch (asynchronous)
//   s_raw      in  raw high-level switch (asynchronous)
//   fault_clr  in  one-cycle fault clear request
//   I          out conditioned low-level signal
//   S          out conditioned high-level signal
//   fault      out sticky sensor-inconsistency flag
module level_sensor_conditioner
  import level_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int FAULT_CYCLES    = DEFAULT_FAULT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  input  logic s_raw,
  input  logic fault_clr,
  output logic I,
  output logic S,
  output logic fault
);

  localparam int FW = $clog2(FAULT_CYCLES) + 1;
  localparam logic [FW-1:0] FMAX = FW'(FAULT_CYCLES);

  // Bit 0 = low-level channel, bit 1 = high-level channel.
  logic [1:0] raw_vec;
  logic [1:0] level_vec;

  assign raw_vec = {s_raw, i_raw};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_vec[gi]),
        .level (level_vec[gi])
      );
    end
  endgenerate

  logic          db_i;
  logic          db_s;
  logic          implausible;
  logic [FW-1:0] fcnt_reg, fcnt_next;
  logic          fault_reg, fault_next;

  assign db_i        = level_vec[0];
  assign db_s        = level_vec[1];
  assign implausible = db_s & ~db_i;

  always_comb begin
    fcnt_next  = '0;
    fault_next = fault_reg;
    if (implausible) begin
      fcnt_next = (fcnt_reg == FMAX) ? fcnt_reg : fcnt_reg + FW'(1);
    end
    if (fault_reg) begin
      // A clear is honoured only when the pair is consistent, which also
      // means the counter is already restarting from 0.
      if (fault_clr && !implausible) begin
        fault_next = 1'b0;
        fcnt_next  = '0;
      end
    end else if (fcnt_next == FMAX) begin
      fault_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_reg  <= '0;
      fault_reg <= 1'b0;
    end else begin
      fcnt_reg  <= fcnt_next;
      fault_reg <= fault_next;
    end
  end

  // Output mux selects between registered values only.
  assign I     = fault_reg ? FAULT_I : db_i;
  assign S     = fault_reg ? FAULT_S : db_s;
  assign fault = fault_reg;

endmodule

// File: tb/tb_level_sensor_conditioner.sv
module tb_level_sensor_conditioner;

  localparam int DB = 4;
  localparam int FC = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_raw = 1'b0;
  logic s_raw = 1'b0;
  logic fault_clr = 1'b0;
  logic I, S, fault;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  level_sensor_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .FAULT_CYCLES   (FC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_raw     (i_raw),
    .s_raw     (s_raw),
    .fault_clr (fault_clr),
    .I         (I),
    .S         (S),
    .fault     (fault)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0b required=%0b", name, $time, act, exp);
    end
  endtask

  // Behavioural model: keeps the raw value seen at each edge. The sample the
  // debouncer acts on at edge n is the raw value from edge n-2; a level flips
  // once the last DB such samples all disagree with it. The fault flag counts
  // consecutive edges that start with the level pair S=1, I=0.
  logic hist_i [0:DB+1];
  logic hist_s [0:DB+1];
  logic m_i = 1'b0, m_s = 1'b0, m_f = 1'b0;
  int   run = 0;
  bit   model_valid = 1'b0;

  initial begin
    logic r, ri, rs, fc, implaus, diff_i, diff_s;
    forever begin
      @(posedge clk);
      r = reset; ri = i_raw; rs = s_raw; fc = fault_clr;
      if (r) begin
        for (int j = 0; j <= DB + 1; j++) begin
          hist_i[j] = 1'b0;
          hist_s[j] = 1'b0;
        end
        m_i = 1'b0; m_s = 1'b0; m_f = 1'b0; run = 0;
        model_valid = 1'b1;
      end else if (model_valid) begin
        implaus = m_s && !m_i;
        run = implaus ? run + 1 : 0;
        if (m_f) begin
          if (fc && !implaus) begin
            m_f = 1'b0;
            run = 0;
          end
        end else if (run >= FC) begin
          m_f = 1'b1;
        end
        for (int j = DB + 1; j >= 1; j--) begin
          hist_i[j] = hist_i[j-1];
          hist_s[j] = hist_s[j-1];
        end
        hist_i[0] = ri;
        hist_s[0] = rs;
        diff_i = 1'b1;
        diff_s = 1'b1;
        for (int j = 2; j <= DB + 1; j++) begin
          if (hist_i[j] == m_i) diff_i = 1'b0;
          if (hist_s[j] == m_s) diff_s = 1'b0;
        end
        if (diff_i) m_i = !m_i;
        if (diff_s) m_s = !m_s;
      end
      #1;
      if (model_valid) begin
        chk("model_I",     I,     m_f ? 1'b1 : m_i);
        chk("model_S",     S,     m_f ? 1'b1 : m_s);
        chk("model_fault", fault, m_f);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset
    tick(2);
    chk("reset_I", I, 1'b0);
    chk("reset_S", S, 1'b0);
    chk("reset_fault", fault, 1'b0);
    $display("txn reset: I=%0b S=%0b fault=%0b", I, S, fault);
    reset = 1'b0;

    // Low switch rises: output at k+5
    tick(1);
    i_raw = 1'b1;
    tick(5);
    chk("i_rise_k4", I, 1'b0);
    tick(1);
    chk("i_rise_k5", I, 1'b1);
    chk("i_rise_S", S, 1'b0);
    chk("i_rise_fault", fault, 1'b0);
    $display("txn i_raw rise: I=%0b S=%0b fault=%0b", I, S, fault);

    // 3-cycle glitch on s_raw is filtered
    tick(2);
    s_raw = 1'b1;
    tick(3);
    s_raw = 1'b0;
    tick(10);
    chk("glitch3_S", S, 1'b0);
    $display("txn s_raw 3-cycle pulse: S=%0b", S);

    // 4-cycle pulse passes: rises at k+5, falls at k+9
    s_raw = 1'b1;
    tick(4);
    s_raw = 1'b0;
    tick(1);
    chk("pulse4_k4", S, 1'b0);
    tick(1);
    chk("pulse4_k5", S, 1'b1);
    tick(3);
    chk("pulse4_k8", S, 1'b1);
    tick(1);
    chk("pulse4_k9", S, 1'b0);
    $display("txn s_raw 4-cycle pulse: S=%0b", S);

    // Full tank, then low switch drops -> fault 8 edges after I falls
    s_raw = 1'b1;
    tick(10);
    chk("full_S", S, 1'b1);
    i_raw = 1'b0;
    tick(5);
    chk("drop_k4_I", I, 1'b1);
    tick(1);
    chk("drop_k5_I", I, 1'b0);
    chk("drop_k5_fault", fault, 1'b0);
    tick(7);
    chk("drop_k12_fault", fault, 1'b0);
    tick(1);
    chk("drop_k13_fault", fault, 1'b1);
    chk("drop_k13_I", I, 1'b1);
    chk("drop_k13_S", S, 1'b1);
    $display("txn implausible pair: I=%0b S=%0b fault=%0b", I, S, fault);

    // Clear ignored while implausible
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    chk("clr_ignored", fault, 1'b1);
    $display("txn fault_clr while implausible: fault=%0b", fault);

    // Restore I, then clear succeeds
    i_raw = 1'b1;
    tick(8);
    chk("restored_fault", fault, 1'b1);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    chk("clr_ok_fault", fault, 1'b0);
    chk("clr_ok_I", I, 1'b1);
    chk("clr_ok_S", S, 1'b1);
    s_raw = 1'b0;
    tick(6);
    chk("after_clr_S", S, 1'b0);
    chk("after_clr_I", I, 1'b1);
    $display("txn fault_clr consistent: I=%0b S=%0b fault=%0b", I, S, fault);

    // Both inputs toggle together
    i_raw = 1'b0;
    s_raw = 1'b1;
    tick(5);
    chk("both_k4_I", I, 1'b1);
    chk("both_k4_S", S, 1'b0);
    tick(1);
    chk("both_k5_I", I, 1'b0);
    chk("both_k5_S", S, 1'b1);
    tick(8);
    chk("both_fault", fault, 1'b1);
    $display("txn simultaneous toggle: I=%0b S=%0b fault=%0b", I, S, fault);

    // Reset mid-debounce with fault set and simultaneous clear
    s_raw = 1'b0;
    tick(4);
    reset = 1'b1;
    fault_clr = 1'b1;
    tick(1);
    chk("midreset_I", I, 1'b0);
    chk("midreset_S", S, 1'b0);
    chk("midreset_fault", fault, 1'b0);
    $display("txn reset mid-debounce: I=%0b S=%0b fault=%0b", I, S, fault);
    reset = 1'b0;
    fault_clr = 1'b0;
    i_raw = 1'b1;
    tick(5);
    chk("post_reset_k4", I, 1'b0);
    tick(1);
    chk("post_reset_k5", I, 1'b1);
    $display("txn post-reset rise: I=%0b", I);

    tick(3);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
